// File: rtl/riscv_multicycle.sv
// riscv_multicycle: multicycle RV32I/RV32E core sharing one handshaked memory port.
// Define RISCV_MULTICYCLE_PERF_EN to add the CycleCnt/InstRetCnt counters.
module riscv_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        MemReq,
  input  logic        MemReady,
  output logic        MemWrite,
  output logic [31:0] Adr,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData,
  output logic [31:0] PC,
  output logic        Halted
`ifdef RISCV_MULTICYCLE_PERF_EN
  ,
  output logic [31:0] CycleCnt,
  output logic [31:0] InstRetCnt
`endif
);

  // state    | meaning
  // FETCH    | request instruction at PC, wait for MemReady
  // DECODE   | read rs1/rs2, precompute branch target
  // MEMADR   | effective address for lw/sw
  // MEMRD    | load request, wait for MemReady
  // MEMWB    | write loaded word to rd
  // MEMWR    | store request, wait for MemReady
  // EXECR    | register-register ALU op
  // EXECI    | register-immediate ALU op
  // ALUWB    | write ALUOut to rd
  // BRANCH   | resolve beq/bne
  // JAL      | jump, link value into ALUOut
  // JALR     | register jump, link value into ALUOut
  // LUI      | upper immediate into ALUOut
  // TRAP     | halted on illegal instruction until reset
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
  } state_t;

  localparam int AW = $clog2(NREGS);

  state_t      state_q, state_d, dec_state;
  logic [31:0] pc_q, pc_d, old_pc_q, old_pc_d, ir_q, ir_d;
  logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, data_q, data_d;
  logic [31:0] adr_q, adr_d, wdata_q, wdata_d, pc_out_q, pc_out_d;
  logic        mem_req_q, mem_req_d, mem_write_q, mem_write_d, halted_q, halted_d;
  logic [31:0] rf_q [NREGS];
  logic        rf_we;
  logic [31:0] rf_wd;
  logic        use_rd, use_rs1, use_rs2;

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, rs1_val, rs2_val, diff;

  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign f3      = ir_q[14:12];
  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];
  assign f7      = ir_q[31:25];
  assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign imm_u   = {ir_q[31:12], 12'b0};
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1[AW-1:0]];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2[AW-1:0]];
  assign diff    = a_q - b_q;

  function automatic logic [31:0] alu(input logic [31:0] x, input logic [31:0] y,
                                      input logic [2:0] op, input logic do_sub);
    case (op)
      3'b111:  alu = x & y;
      3'b110:  alu = x | y;
      3'b010:  alu = {31'b0, $signed(x) < $signed(y)};
      default: alu = do_sub ? x - y : x + y;
    endcase
  endfunction

  always_comb begin
    dec_state = S_TRAP;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (opcode)
      7'b0000011: if (f3 == 3'b010) begin dec_state = S_MEMADR; use_rd = 1'b1; use_rs1 = 1'b1; end
      7'b0100011: if (f3 == 3'b010) begin dec_state = S_MEMADR; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b0110011:
        if ((f7 == 7'b0000000 && f3 inside {3'b000, 3'b111, 3'b110, 3'b010}) ||
            (f7 == 7'b0100000 && f3 == 3'b000)) begin
          dec_state = S_EXECR; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
      7'b0010011:
        if (f3 inside {3'b000, 3'b111, 3'b110, 3'b010}) begin
          dec_state = S_EXECI; use_rd = 1'b1; use_rs1 = 1'b1;
        end
      7'b1100011: if (f3[2:1] == 2'b00) begin dec_state = S_BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b1101111: begin dec_state = S_JAL; use_rd = 1'b1; end
      7'b1100111: if (f3 == 3'b000) begin dec_state = S_JALR; use_rd = 1'b1; use_rs1 = 1'b1; end
      7'b0110111: begin dec_state = S_LUI; use_rd = 1'b1; end
      default: ;
    endcase
    // RV32E: any referenced register above x15 is illegal
    if (NREGS < 32 && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4])))
      dec_state = S_TRAP;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    old_pc_d  = old_pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    data_d    = data_q;
    rf_we     = 1'b0;
    rf_wd     = alu_out_q;
    case (state_q)
      S_FETCH: if (MemReady) begin
        ir_d = ReadData; old_pc_d = pc_q; pc_d = pc_q + 32'd4; state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d = rs1_val; b_d = rs2_val; alu_out_d = old_pc_q + imm_b; state_d = dec_state;
      end
      S_MEMADR: begin
        alu_out_d = a_q + (opcode[5] ? imm_s : imm_i);
        state_d   = opcode[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: if (MemReady) begin data_d = ReadData; state_d = S_MEMWB; end
      S_MEMWB: begin rf_we = 1'b1; rf_wd = data_q; state_d = S_FETCH; end
      S_MEMWR: if (MemReady) state_d = S_FETCH;
      S_EXECR: begin alu_out_d = alu(a_q, b_q, f3, f7[5]); state_d = S_ALUWB; end
      S_EXECI: begin alu_out_d = alu(a_q, imm_i, f3, 1'b0); state_d = S_ALUWB; end
      S_ALUWB: begin rf_we = 1'b1; state_d = S_FETCH; end
      S_BRANCH: begin
        if ((diff == 32'd0) ^ f3[0]) pc_d = alu_out_q;
        state_d = S_FETCH;
      end
      S_JAL: begin pc_d = old_pc_q + imm_j; alu_out_d = old_pc_q + 32'd4; state_d = S_ALUWB; end
      S_JALR: begin
        pc_d = (a_q + imm_i) & ~32'd1; alu_out_d = old_pc_q + 32'd4; state_d = S_ALUWB;
      end
      S_LUI: begin alu_out_d = imm_u; state_d = S_ALUWB; end
      S_TRAP: ;
      default: state_d = S_TRAP;
    endcase
    // outputs are registered from the next state so they are glitch-free and held during waits
    mem_req_d   = state_d inside {S_FETCH, S_MEMRD, S_MEMWR};
    mem_write_d = (state_d == S_MEMWR);
    adr_d       = ((state_d == S_FETCH) ? pc_d : alu_out_d) & ~32'd3;
    wdata_d     = (state_d == S_MEMWR) ? b_d : wdata_q;
    halted_d    = (state_d == S_TRAP);
    pc_out_d    = (state_d == S_FETCH) ? pc_d : old_pc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      old_pc_q    <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_out_q   <= '0;
      data_q      <= '0;
      mem_req_q   <= 1'b1;
      mem_write_q <= 1'b0;
      adr_q       <= RESET_PC & ~32'd3;
      wdata_q     <= '0;
      halted_q    <= 1'b0;
      pc_out_q    <= RESET_PC;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      old_pc_q    <= old_pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_out_q   <= alu_out_d;
      data_q      <= data_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      halted_q    <= halted_d;
      pc_out_q    <= pc_out_d;
      if (rf_we && rd != 5'd0) rf_q[rd[AW-1:0]] <= rf_wd;
    end
  end

  assign MemReq    = mem_req_q;
  assign MemWrite  = mem_write_q;
  assign Adr       = adr_q;
  assign WriteData = wdata_q;
  assign Halted    = halted_q;
  assign PC        = pc_out_q;

`ifdef RISCV_MULTICYCLE_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d, inst_ret_q, inst_ret_d;
  assign cycle_cnt_d = cycle_cnt_q + 32'd1;
  assign inst_ret_d  = inst_ret_q + {31'b0, (state_q != S_FETCH && state_d == S_FETCH)};

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      inst_ret_q  <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      inst_ret_q  <= inst_ret_d;
    end
  end

  assign CycleCnt   = cycle_cnt_q;
  assign InstRetCnt = inst_ret_q;
`endif

endmodule

// File: doc/riscv_multicycle.md
Name: riscv_multicycle

Overview:
- Parametrised multicycle successor to the single-cycle RV32 core.
- One shared instruction/data memory port with a ready handshake, so memory may insert wait states.
- Control FSM, datapath, register file and ALU live in one block.
- Adds bne, lui, jalr, configurable reset vector, RV32E register count and a halt-on-illegal trap.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NREGS, 32, architectural register count: 32 (RV32I) or 16 (RV32E; rd/rs index bit 4 set = illegal).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- MemReq  out  1  memory transaction request.
- MemReady  in  1  memory completes current transaction this cycle.
- MemWrite  out  1  request is a word store.
- Adr  out  32  word-aligned byte address.
- WriteData  out  32  store data.
- ReadData  in  32  load/fetch data, valid in the MemReady cycle.
- PC  out  32  address of the instruction currently executing.
- Halted  out  1  core stopped on an illegal instruction.

Behaviour:
- Reset (sync, active-high):
  - PC=RESET_PC; FSM enters FETCH; all registers clear to 0.
  - Outputs: MemWrite=0, Halted=0, WriteData=0.
  - On the cycle after reset deasserts: MemReq=1, Adr=RESET_PC.
  - Reset asserted mid-instruction or mid-transaction aborts it; no register-file or memory side effect is committed after the reset edge.
- Handshake:
  - A transaction completes on any cycle with MemReq=1 and MemReady=1.
  - Adr, MemWrite and WriteData are held stable while MemReq=1 and MemReady=0.
  - MemReady while MemReq=0 is ignored.
- Supported instructions: lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, bne, jal, jalr, lui. All other opcodes/funct combinations are illegal.
- FSM states and transitions:
  - FETCH: Adr=PC, MemReq=1; on MemReady latch IR, OldPC=PC, PC=PC+4 -> DECODE.
  - DECODE: read rs1/rs2; ALUOut=OldPC+immB.
    - lw/sw -> MEMADR; R-type -> EXECR; I-ALU -> EXECI; beq/bne -> BRANCH; jal -> JAL; jalr -> JALR; lui -> LUI; illegal -> TRAP.
  - MEMADR: ALUOut=rs1+imm -> MEMRD (lw) or MEMWR (sw).
  - MEMRD: Adr=ALUOut, MemReq=1; on MemReady latch Data -> MEMWB.
  - MEMWB: rd=Data -> FETCH.
  - MEMWR: Adr=ALUOut, WriteData=rs2, MemWrite=1, MemReq=1; on MemReady -> FETCH.
  - EXECR / EXECI: ALUOut=op -> ALUWB.
  - ALUWB: rd=ALUOut -> FETCH.
  - BRANCH: compute rs1-rs2; if taken (Zero for beq, !Zero for bne) PC=ALUOut -> FETCH.
  - JAL: PC=OldPC+immJ; rd=OldPC+4 -> FETCH.
  - JALR: PC=(rs1+immI)&~1; rd=OldPC+4 -> FETCH.
  - LUI: rd={imm[31:12],12'b0} -> FETCH.
  - TRAP: Halted=1, MemReq=0; stays in TRAP until reset.
- Latency with zero wait states:
  - beq/bne: 3 cycles.
  - sw, R-type, I-ALU, jal, jalr, lui: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1 to FETCH/MEMRD/MEMWR.
- Writes to x0 are discarded; x0 always reads 0.
- Arithmetic: 32-bit wrap-around, no overflow flag. slt/slti signed. Immediates sign-extended. PC arithmetic wraps at 2^32.
- Misaligned addresses: the two LSBs are forced to 0 on Adr.
- PC output holds OldPC from DECODE onward, and the fetch address in FETCH.

Optional Feature:
- Macro RISCV_MULTICYCLE_PERF_EN.
- When defined:
  - Adds outputs CycleCnt[31:0] and InstRetCnt[31:0], both cleared by reset.
  - CycleCnt increments every non-reset cycle, including in TRAP.
  - InstRetCnt increments on the cycle the FSM returns to FETCH from a completed instruction.
  - Both counters wrap at 2^32.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=32'h100, MemReady tied 1 -> first MemReq=1, Adr=32'h100; addi x1,x0,5 then addi x2,x0,7 -> x2=7 written 4 cycles after x1.
- add x3,x1,x2; sw x3,0x40(x0) -> MemWrite=1, Adr=32'h40, WriteData=12, 8 cycles after add fetch starts.
- lw x4,0x40(x0) with MemReady held low 3 cycles in MEMRD -> Adr/MemWrite stable throughout; x4=12; instruction takes 8 cycles.
- beq x1,x1,-8 taken -> next fetch Adr = branch PC-8; bne x1,x1 not taken -> fetch at PC+4; jalr x5,8(x6) with x6=32'h203 -> PC=32'h20A, x5=OldPC+4.
- Illegal opcode 7'h7F fetched -> Halted=1 one cycle after DECODE, MemReq stays 0; reset asserted -> Halted=0, fetch restarts at RESET_PC.
- NREGS=16, add x17,x1,x2 -> TRAP with x17 unchanged; reset asserted during a MEMWR wait state -> no store completes, the core restarts at RESET_PC.
